// File: rtl/traffic_light_intersection.sv
// Purpose: fixed-time four-way traffic-light controller with protected left-turn phases (8-state Moore FSM).
// Latency: lamp outputs decode the state register combinationally; each state holds for its dwell count in cycles.
// Backpressure: none; free-running from clk, with synchronous active-high reset forcing the NS left-green state.
module traffic_light_intersection #(
  parameter int LEFT_TIME   = 5,  // cycles in each Left Green state (1..255)
  parameter int GREEN_TIME  = 5,  // cycles in each Straight Green state (1..255)
  parameter int YELLOW_TIME = 2   // cycles in each Left/Straight Yellow state (1..255)
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] north_tl,
  output logic [3:0] south_tl,
  output logic [3:0] east_tl,
  output logic [3:0] west_tl
);

  // Lamp bit map: [3]=left arrow, [2]=green, [1]=yellow, [0]=red.
  localparam logic [3:0] ALL_RED = 4'b0001;
  localparam logic [3:0] LEFT_G  = 4'b1001;
  localparam logic [3:0] LEFT_Y  = 4'b1010;
  localparam logic [3:0] STR_G   = 4'b0100;
  localparam logic [3:0] STR_Y   = 4'b0010;

  // Terminal counts are precomputed as dwell-1. Every dwell is at least 1,
  // so these never underflow, and a dwell of 1 gives a terminal count of 0,
  // meaning the state advances on the very first edge after entry.
  localparam logic [7:0] LEFT_LAST   = 8'(LEFT_TIME - 1);
  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TIME - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);

  // Encoding is sequential so that advancing is a plain increment and
  // S7 wraps to S0 through the natural 3-bit overflow.
  typedef enum logic [2:0] {
    S0_NS_LEFT_G = 3'd0,
    S1_NS_LEFT_Y = 3'd1,
    S2_NS_STR_G  = 3'd2,
    S3_NS_STR_Y  = 3'd3,
    S4_EW_LEFT_G = 3'd4,
    S5_EW_LEFT_Y = 3'd5,
    S6_EW_STR_G  = 3'd6,
    S7_EW_STR_Y  = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dwell_last;
  logic       bad_state;
  logic [3:0] ns_lamp;
  logic [3:0] ew_lamp;

  // State and dwell-counter registers with synchronous reset to S0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0_NS_LEFT_G;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Select the terminal count for the current state; flag any undecoded code.
  always_comb begin
    dwell_last = LEFT_LAST;
    bad_state  = 1'b0;
    case (state_q)
      S0_NS_LEFT_G, S4_EW_LEFT_G: dwell_last = LEFT_LAST;
      S2_NS_STR_G,  S6_EW_STR_G:  dwell_last = GREEN_LAST;
      S1_NS_LEFT_Y, S3_NS_STR_Y,
      S5_EW_LEFT_Y, S7_EW_STR_Y:  dwell_last = YELLOW_LAST;
      default:                    bad_state  = 1'b1;
    endcase
  end

  // Next state: hold and count until the terminal count, then advance and clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    if (bad_state) begin
      // Recovery path: restart the cycle cleanly from NS left green.
      state_d = S0_NS_LEFT_G;
      cnt_d   = 8'd0;
    end else if (cnt_q == dwell_last) begin
      state_d = state_t'(3'(state_q + 3'd1));
      cnt_d   = 8'd0;
    end
  end

  // Moore lamp decode: exactly one approach pair is ever off ALL_RED.
  always_comb begin
    ns_lamp = ALL_RED;
    ew_lamp = ALL_RED;
    case (state_q)
      S0_NS_LEFT_G: ns_lamp = LEFT_G;
      S1_NS_LEFT_Y: ns_lamp = LEFT_Y;
      S2_NS_STR_G:  ns_lamp = STR_G;
      S3_NS_STR_Y:  ns_lamp = STR_Y;
      S4_EW_LEFT_G: ew_lamp = LEFT_G;
      S5_EW_LEFT_Y: ew_lamp = LEFT_Y;
      S6_EW_STR_G:  ew_lamp = STR_G;
      S7_EW_STR_Y:  ew_lamp = STR_Y;
      default: begin
        ns_lamp = ALL_RED;
        ew_lamp = ALL_RED;
      end
    endcase
  end

  // Opposing approaches of a phase always show the same aspect.
  assign north_tl = ns_lamp;
  assign south_tl = ns_lamp;
  assign east_tl  = ew_lamp;
  assign west_tl  = ew_lamp;

endmodule

// File: tb/tb_traffic_light_intersection.sv
// Scoreboard bench: a driver issues randomized resets and pushes expected lamps
// computed from elapsed time in the signal cycle; a monitor pops and compares on negedge.
module tb_traffic_light_intersection;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] na, sa, ea, wa;
  logic [3:0] nb, sb, eb, wb;

  always #5 clk = ~clk;

  traffic_light_intersection u_dut_a (
    .clk(clk), .reset(rst_a),
    .north_tl(na), .south_tl(sa), .east_tl(ea), .west_tl(wa)
  );

  traffic_light_intersection #(.LEFT_TIME(1), .GREEN_TIME(3), .YELLOW_TIME(1)) u_dut_b (
    .clk(clk), .reset(rst_b),
    .north_tl(nb), .south_tl(sb), .east_tl(eb), .west_tl(wb)
  );

  typedef struct packed {
    logic [3:0] ns_a;
    logic [3:0] ew_a;
    logic [3:0] ns_b;
    logic [3:0] ew_b;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference: t = edges since the last sampled reset. The cycle is a list of
  // (duration, NS aspect, EW aspect) intervals; walk it with t mod period.
  function automatic logic [7:0] model(input int t, input int l, input int g, input int y);
    int         dur[8];
    logic [3:0] code[4];
    int         period;
    int         tm;
    int         ph;
    dur  = '{l, y, g, y, l, y, g, y};
    code = '{4'b1001, 4'b1010, 4'b0100, 4'b0010};
    period = 2 * (l + g + 2 * y);
    tm = t % period;
    ph = 0;
    for (int i = 0; i < 8; i++) begin
      if (tm < dur[i]) begin
        ph = i;
        break;
      end
      tm = tm - dur[i];
    end
    if (ph < 4) return {code[ph], 4'b0001};
    else        return {4'b0001, code[ph - 4]};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got=%b expected=%b", name, $time, act, req);
    end
  endtask

  task automatic check_ok(input string name, input logic cond);
    checks++;
    if (cond !== 1'b1) begin
      failures++;
      $display("FAIL %s at %0t: condition got=%b expected=1", name, $time, cond);
    end
  endtask

  function automatic logic one_hot3(input logic [3:0] v);
    return (v[2:0] == 3'b001) || (v[2:0] == 3'b010) || (v[2:0] == 3'b100);
  endfunction

  // Driver: advances the model on each edge, pushes expectations, then chooses next reset.
  initial begin
    int         t_a, t_b;
    bit         s6_done;
    exp_t       e;
    logic [7:0] m;
    rst_a = 1'b1;
    rst_b = 1'b1;
    t_a = 0;
    t_b = 0;
    s6_done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      t_a = rst_a ? 0 : t_a + 1;
      t_b = rst_b ? 0 : t_b + 1;
      m = model(t_a, 5, 5, 2);
      e.ns_a = m[7:4];
      e.ew_a = m[3:0];
      m = model(t_b, 1, 3, 1);
      e.ns_b = m[7:4];
      e.ew_b = m[3:0];
      sb_q.push_back(e);
      #1;
      if (cyc < 1) begin
        rst_a = 1'b1;
        rst_b = 1'b1;
      end else begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        if (!s6_done && cyc > 70 && e.ew_a == 4'b0100) begin
          rst_a = 1'b1;
          s6_done = 1'b1;
        end else if (cyc > 150 && $urandom_range(0, 39) == 0) begin
          rst_a = 1'b1;
        end
        if (cyc > 60 && $urandom_range(0, 29) == 0) rst_b = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    check_ok("s6_reset_exercised", s6_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: compares DUT lamps against the scoreboard and checks safety invariants.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("a_north", na, x.ns_a);
        check("a_east",  ea, x.ew_a);
        check("a_south_eq_north", sa, na);
        check("a_west_eq_east",   wa, ea);
        check_ok("a_not_both_active", (na == 4'b0001) || (ea == 4'b0001));
        check_ok("a_one_hot", one_hot3(na) && one_hot3(ea));
        check("b_north", nb, x.ns_b);
        check("b_east",  eb, x.ew_b);
        check("b_south_eq_north", sb, nb);
        check("b_west_eq_east",   wb, eb);
        check_ok("b_not_both_active", (nb == 4'b0001) || (eb == 4'b0001));
        check_ok("b_one_hot", one_hot3(nb) && one_hot3(eb));
      end
    end
  end

endmodule
